frame_buffer_writer: RTL and testbench

- Write-side front end for the double frame buffer, in the I_clka domain.
- Takes the byte stream from the HDMI capture path and packs it into DATA_WIDTH_A-bit words, one word per block, for all BANK_COUNT*BLOCK_COUNT blocks in parallel.
- Drives the flat write address/data buses and a one-cycle write pulse.
- Issues a swap trigger once a full frame is written, handing the frame to the matrix read side.

---
 rtl/frame_buffer_writer.sv | 90 +++++++++
 tb/tb_frame_buffer_writer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: packs captured bytes into per-block words and writes one word row per strobe
// Ports:
//   I_clka, I_rst_n           write clock, async active-low reset
//   I_frame_start             pulse; the next valid byte (same cycle included) is byte 0
//   I_byte_valid, I_byte      byte stream, no backpressure
//   O_ada_flat, O_din_flat    row address replicated per block, packed words per block
//   O_clk_data_in             one-cycle write strobe
//   O_swap_trigger            SWAP_LEN-cycle pulse after the last row of a frame
//   O_busy, O_frame_abort     frame in progress, restart of an incomplete frame
module frame_buffer_writer #(
  parameter int BYTES_PER_BLOCK = 2250,
  parameter int BANK_COUNT = 6,
  parameter int BLOCK_COUNT = 2,
  parameter int DATA_WIDTH_A = 32,
  parameter int FRAME_WORDS = (BYTES_PER_BLOCK * 8) / DATA_WIDTH_A,
  parameter int ADDR_W = $clog2(FRAME_WORDS),
  parameter int SWAP_LEN = 4
) (
  input  logic I_clka,
  input  logic I_rst_n,
  input  logic I_frame_start,
  input  logic I_byte_valid,
  input  logic [7:0] I_byte,
  output logic [BANK_COUNT*BLOCK_COUNT*ADDR_W-1:0] O_ada_flat,
  output logic [BANK_COUNT*BLOCK_COUNT*DATA_WIDTH_A-1:0] O_din_flat,
  output logic O_clk_data_in,
  output logic O_swap_trigger,
  output logic O_busy,
  output logic O_frame_abort
);
  localparam int NB = BANK_COUNT * BLOCK_COUNT;
  localparam int L = DATA_WIDTH_A / 8;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = $clog2(SWAP_LEN + 2);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lane_q, lane_d, lane_e;
  logic [BW-1:0] blk_q, blk_d, blk_e;
  logic [ADDR_W-1:0] row_q, row_d, row_e;
  logic [NB*DATA_WIDTH_A-1:0] stg_q, stg_d;
  logic [SW-1:0] sc_q;
  logic accept, commit, last;
  // A frame start in the same cycle makes this byte byte 0, so the effective
  // position is taken from zeroed counters.
  always_comb begin
    lane_e = I_frame_start ? '0 : lane_q;
    blk_e = I_frame_start ? '0 : blk_q;
    row_e = I_frame_start ? '0 : row_q;
    accept = I_byte_valid && (I_frame_start || state_q == FILL);
    commit = accept && lane_e == LW'(L - 1) && blk_e == BW'(NB - 1);
    last = commit && row_e == ADDR_W'(FRAME_WORDS - 1);
    stg_d = stg_q;
    if (accept) stg_d[(int'(blk_e) * L + int'(lane_e)) * 8 +: 8] = I_byte;
    lane_d = !accept ? lane_e : (lane_e == LW'(L - 1)) ? '0 : lane_e + 1'b1;
    blk_d = (!accept || lane_e != LW'(L - 1)) ? blk_e : (blk_e == BW'(NB - 1)) ? '0 : blk_e + 1'b1;
    row_d = last ? '0 : commit ? row_e + 1'b1 : row_e;
    state_d = last ? IDLE : I_frame_start ? FILL : state_q;
  end
  always_ff @(posedge I_clka or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
      lane_q <= '0;
      blk_q <= '0;
      row_q <= '0;
      stg_q <= '0;
      sc_q <= '0;
      O_ada_flat <= '0;
      O_din_flat <= '0;
      O_clk_data_in <= 1'b0;
      O_frame_abort <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      blk_q <= blk_d;
      row_q <= row_d;
      stg_q <= stg_d;
      O_clk_data_in <= commit;
      O_frame_abort <= I_frame_start && state_q == FILL;
      if (commit) begin
        O_din_flat <= stg_d;
        O_ada_flat <= {NB{row_e}};
      end
      sc_q <= last ? SW'(SWAP_LEN + 1) : (sc_q != '0) ? sc_q - 1'b1 : sc_q;
    end
  end
  // Counter loads SWAP_LEN+1 so the pulse starts one cycle after the final strobe.
  assign O_swap_trigger = sc_q != '0 && sc_q <= SW'(SWAP_LEN);
  assign O_busy = state_q == FILL;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: table, directed and random checks of frame_buffer_writer against a byte-index model
module tb_frame_buffer_writer;
  localparam int NB = 2;
  localparam int AW = 2;
  localparam int DW = 32;
  logic I_clka = 1'b0;
  logic I_rst_n = 1'b0;
  logic I_frame_start = 1'b0;
  logic I_byte_valid = 1'b0;
  logic [7:0] I_byte = 8'h00;
  logic [NB*AW-1:0] O_ada_flat;
  logic [NB*DW-1:0] O_din_flat;
  logic O_clk_data_in, O_swap_trigger, O_busy, O_frame_abort;
  frame_buffer_writer #(
    .BYTES_PER_BLOCK(16), .BANK_COUNT(1), .BLOCK_COUNT(2), .DATA_WIDTH_A(32), .SWAP_LEN(4)
  ) dut (
    .I_clka(I_clka), .I_rst_n(I_rst_n), .I_frame_start(I_frame_start),
    .I_byte_valid(I_byte_valid), .I_byte(I_byte), .O_ada_flat(O_ada_flat),
    .O_din_flat(O_din_flat), .O_clk_data_in(O_clk_data_in), .O_swap_trigger(O_swap_trigger),
    .O_busy(O_busy), .O_frame_abort(O_frame_abort)
  );
  always #5 I_clka = ~I_clka;
  int checks = 0;
  int failures = 0;
  logic [7:0] fb[32];
  bit m_in;
  int m_k;
  logic [63:0] m_din;
  logic [3:0] m_ada;
  int cyc = 0;
  int sw_from = -10;
  int sw_to = -10;
  int n_strobe = 0;
  int n_abort = 0;
  int n_swap = 0;
  typedef struct {bit fs; bit v; logic [7:0] b; bit clk; bit busy; bit ab;} vec_t;
  vec_t tbl[11];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step(input bit fs, input bit v, input logic [7:0] b);
    bit e_clk, e_ab;
    int r;
    I_frame_start = fs;
    I_byte_valid = v;
    I_byte = b;
    e_ab = fs && m_in;
    e_clk = 1'b0;
    if (fs) begin
      m_in = 1'b1;
      m_k = 0;
    end
    if (v && m_in) begin
      fb[m_k] = b;
      if (m_k % 8 == 7) begin
        r = m_k / 8;
        e_clk = 1'b1;
        m_ada = {2{r[1:0]}};
        for (int j = 0; j < 8; j++) m_din[j*8 +: 8] = fb[r*8 + j];
        if (r == 3) begin
          m_in = 1'b0;
          sw_from = cyc + 1;
          sw_to = cyc + 4;
        end
      end
      m_k++;
    end
    @(posedge I_clka);
    #1;
    chk("strobe", 64'(O_clk_data_in), 64'(e_clk));
    chk("abort", 64'(O_frame_abort), 64'(e_ab));
    chk("busy", 64'(O_busy), 64'(m_in));
    chk("swap", 64'(O_swap_trigger), 64'(cyc >= sw_from && cyc <= sw_to));
    chk("din", O_din_flat, m_din);
    chk("ada", 64'(O_ada_flat), 64'(m_ada));
    n_strobe += int'(O_clk_data_in);
    n_abort += int'(O_frame_abort);
    n_swap += int'(O_swap_trigger);
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask
  task automatic do_reset();
    I_frame_start = 1'b0;
    I_byte_valid = 1'b0;
    I_rst_n = 1'b0;
    m_in = 1'b0;
    m_k = 0;
    m_din = '0;
    m_ada = '0;
    sw_from = -10;
    sw_to = -10;
    #2;
    chk("rst_outputs", {O_din_flat[59:0], O_ada_flat}, 64'h0);
    chk("rst_flags", 64'({O_din_flat[63:60], O_clk_data_in, O_swap_trigger, O_busy, O_frame_abort}), 64'h0);
    @(posedge I_clka);
    #1;
    I_rst_n = 1'b1;
    cyc++;
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i < 8; i++) tbl[i] = '{1'b0, 1'b1, 8'(i), i == 7, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].fs, tbl[i].v, tbl[i].b);
      chk("tbl_strobe", 64'(O_clk_data_in), 64'(tbl[i].clk));
      chk("tbl_busy", 64'(O_busy), 64'(tbl[i].busy));
      chk("tbl_abort", 64'(O_frame_abort), 64'(tbl[i].ab));
    end
    do_reset();
    // contiguous frame
    n_strobe = 0; n_swap = 0;
    step(1'b1, 1'b1, 8'h00);
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b1, 8'(i));
      if (i == 7) begin
        chk("row0_din", O_din_flat, 64'h07060504_03020100);
        chk("row0_ada", 64'(O_ada_flat), 64'h0);
      end
    end
    chk("row3_ada", 64'(O_ada_flat), 64'hF);
    idle(6);
    chk("t1_strobes", 64'(n_strobe), 64'd4);
    chk("t1_swap_len", 64'(n_swap), 64'd4);
    // gapped valid
    n_strobe = 0; n_swap = 0;
    step(1'b1, 1'b1, 8'h00);
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b0, 8'hEE);
      step(1'b0, 1'b1, 8'(i));
    end
    idle(6);
    chk("t2_strobes", 64'(n_strobe), 64'd4);
    chk("t2_swap_len", 64'(n_swap), 64'd4);
    // abort then full frame
    n_strobe = 0; n_swap = 0; n_abort = 0;
    step(1'b1, 1'b1, 8'h00);
    for (int i = 1; i < 12; i++) step(1'b0, 1'b1, 8'(i));
    chk("t3_pre_strobes", 64'(n_strobe), 64'd1);
    step(1'b1, 1'b1, 8'h80);
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 8'(8'h80 + i));
    idle(6);
    chk("t3_aborts", 64'(n_abort), 64'd1);
    chk("t3_strobes", 64'(n_strobe), 64'd5);
    chk("t3_swap_len", 64'(n_swap), 64'd4);
    // overrun bytes ignored
    n_strobe = 0;
    step(1'b1, 1'b1, 8'h40);
    for (int i = 1; i < 40; i++) step(1'b0, 1'b1, 8'(8'h40 + i));
    chk("t4_strobes", 64'(n_strobe), 64'd4);
    chk("t4_busy", 64'(O_busy), 64'd0);
    idle(6);
    // restart during swap pulse
    n_swap = 0;
    step(1'b1, 1'b1, 8'h10);
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
    idle(2);
    step(1'b1, 1'b1, 8'hAA);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 8'(8'hA0 + i));
    chk("t5_lane0", 64'(O_din_flat[7:0]), 64'hAA);
    chk("t5_swap_len", 64'(n_swap), 64'd4);
    // reset mid-frame
    do_reset();
    step(1'b1, 1'b1, 8'h00);
    for (int i = 1; i < 20; i++) step(1'b0, 1'b1, 8'(i));
    do_reset();
    n_swap = 0;
    idle(8);
    chk("t6_no_swap", 64'(n_swap), 64'd0);
    step(1'b1, 1'b1, 8'h30);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 8'(8'h30 + i));
    chk("t6_row0_ada", 64'(O_ada_flat), 64'h0);
    chk("t6_row0_din", O_din_flat, 64'h37363534_33323130);
    // random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 70) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
